reg_file_mp: RTL and testbench

Parametrised multi-port integer register file for the next-generation core, which has dual-issue and multiple writeback lanes. It provides NUM_RD combinational read ports and NUM_WR synchronous write ports. Writes bypass to reads in the same cycle. A per-register busy scoreboard is set on issue (alloc) and cleared on writeback. The block sits between decode/issue (read and alloc) and writeback (write).

---
 rtl/reg_file_mp_if.sv | 30 +++
 rtl/reg_file_mp.sv | 112 +++++++++++
 tb/tb_reg_file_mp.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// Bus bundle between issue/writeback logic (master) and the multi-port register file (slave).
// Ports are packed per lane: read port k uses rd_addr[k*AW +: AW] and rd_data[k*XLEN +: XLEN].
interface reg_file_mp_if #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   alloc_en;
  logic [AW-1:0]          alloc_addr;
  logic                   wr_conflict;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_busy, wr_conflict
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_busy, wr_conflict
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-to-read bypass, a per-register busy
// scoreboard (set on alloc, cleared on writeback) and write-write collision reporting.
module reg_file_mp #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_mp_if.slave  bus
);
  localparam int   AW = $clog2(NREGS);
  localparam logic ZR = (ZERO_REG != 0);

  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic              wr_conflict_q;
  logic              wr_conflict_d;

  logic [AW-1:0]     wa [NUM_WR];
  logic [XLEN-1:0]   wd [NUM_WR];
  logic [NUM_WR-1:0] wr_valid;

  // A write to x0 with ZERO_REG set is discarded everywhere: no update, bypass, clear or collision.
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wa[j]       = bus.wr_addr[j*AW +: AW];
      wd[j]       = bus.wr_data[j*XLEN +: XLEN];
      wr_valid[j] = bus.wr_en[j] && !(ZR && (wa[j] == '0));
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_valid[j]) begin
        regs_d[wa[j]] = wd[j];
      end
    end
  end

  always_comb begin
    wr_conflict_d = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_valid[i] && wr_valid[j] && (wa[i] == wa[j])) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  // A new producer allocated in the same cycle as a writeback keeps the register busy.
  always_comb begin
    busy_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      logic set_r;
      logic clr_r;
      set_r = bus.alloc_en && (bus.alloc_addr == AW'(r)) && !(ZR && (r == 0));
      clr_r = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_valid[j] && (wa[j] == AW'(r))) begin
          clr_r = 1'b1;
        end
      end
      busy_d[r] = set_r | (busy_q[r] & ~clr_r);
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [AW-1:0]   ra;
      logic            hit;
      logic [XLEN-1:0] byp;
      ra  = bus.rd_addr[k*AW +: AW];
      hit = 1'b0;
      byp = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_valid[j] && (wa[j] == ra)) begin
          hit = 1'b1;
          byp = wd[j];
        end
      end
      if (!reset && !(ZR && (ra == '0))) begin
        bus.rd_data[k*XLEN +: XLEN] = hit ? byp : regs_q[ra];
        bus.rd_busy[k]              = busy_q[ra] & ~hit;
      end
    end
  end

  assign bus.wr_conflict = wr_conflict_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp with two read and two write ports: reset, bypass,
// x0 handling, scoreboard timing, write collisions and reset in mid-operation.
module tb_reg_file_mp;
  localparam int XLEN   = 64;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

  reg_file_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en      = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.alloc_en   = 1'b0;
    bus.alloc_addr = '0;
  endtask

  task automatic set_read(input int k, input logic [AW-1:0] a);
    bus.rd_addr[k*AW +: AW] = a;
  endtask

  task automatic set_write(input int j, input logic [AW-1:0] a, input logic [63:0] d);
    bus.wr_en[j]                = 1'b1;
    bus.wr_addr[j*AW +: AW]     = a;
    bus.wr_data[j*XLEN +: XLEN] = d;
  endtask

  task automatic alloc(input logic [AW-1:0] a);
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = a;
  endtask

  function automatic logic [63:0] rdata(input int k);
    return bus.rd_data[k*XLEN +: XLEN];
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.rd_addr  = '0;
    idle();

    // Reset for two cycles, then read x5 / x31
    tick();
    tick();
    reset = 1'b0;
    set_read(0, 5'd5);
    set_read(1, 5'd31);
    #1;
    check_output("reset_rd0", rdata(0), 64'h0);
    check_output("reset_rd1", rdata(1), 64'h0);
    check_output("reset_busy", {62'h0, bus.rd_busy}, 64'h0);
    check_output("reset_conflict", {63'h0, bus.wr_conflict}, 64'h0);

    // Write x3, read it back on both ports next cycle
    set_write(0, 5'd3, 64'hDEAD_BEEF_0000_0001);
    tick();
    idle();
    set_read(0, 5'd3);
    set_read(1, 5'd3);
    #1;
    check_output("x3_rd0", rdata(0), 64'hDEAD_BEEF_0000_0001);
    check_output("x3_rd1", rdata(1), 64'hDEAD_BEEF_0000_0001);

    // x0 ignores writes and never bypasses
    set_write(0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    set_read(0, 5'd0);
    #1;
    check_output("x0_bypass", rdata(0), 64'h0);
    tick();
    idle();
    #1;
    check_output("x0_stored", rdata(0), 64'h0);

    // Bypass onto a busy register hides busy
    alloc(5'd7);
    tick();
    idle();
    set_read(0, 5'd7);
    set_read(1, 5'd7);
    #1;
    check_output("x7_busy", {63'h0, bus.rd_busy[0]}, 64'h1);
    set_write(0, 5'd7, 64'h1234);
    #1;
    check_output("x7_bypass_data", rdata(0), 64'h1234);
    check_output("x7_bypass_busy", {62'h0, bus.rd_busy}, 64'h0);
    tick();
    idle();
    #1;
    check_output("x7_stored", rdata(1), 64'h1234);
    check_output("x7_not_busy", {63'h0, bus.rd_busy[1]}, 64'h0);

    // Alloc x9 at t: busy visible t+1..t+3, cleared by write at t+3
    set_read(0, 5'd9);
    set_read(1, 5'd9);
    alloc(5'd9);
    #1;
    check_output("x9_busy_t0", {63'h0, bus.rd_busy[1]}, 64'h0);
    tick();
    idle();
    #1;
    check_output("x9_busy_t1", {63'h0, bus.rd_busy[1]}, 64'h1);
    tick();
    check_output("x9_busy_t2", {63'h0, bus.rd_busy[0]}, 64'h1);
    tick();
    check_output("x9_busy_t3", {63'h0, bus.rd_busy[0]}, 64'h1);
    set_write(1, 5'd9, 64'h55);
    #1;
    check_output("x9_bypass_busy_t3", {63'h0, bus.rd_busy[0]}, 64'h0);
    tick();
    idle();
    #1;
    check_output("x9_busy_t4", {62'h0, bus.rd_busy}, 64'h0);
    check_output("x9_data_t4", rdata(0), 64'h55);

    // Alloc and write of the same register: new producer wins
    alloc(5'd9);
    set_write(0, 5'd9, 64'h66);
    tick();
    idle();
    #1;
    check_output("x9_alloc_wr_busy", {63'h0, bus.rd_busy[0]}, 64'h1);
    check_output("x9_alloc_wr_data", rdata(1), 64'h66);

    // Write-write collision on x4: port 1 wins, conflict pulses one cycle
    set_read(0, 5'd4);
    set_read(1, 5'd4);
    set_write(0, 5'd4, 64'hA);
    set_write(1, 5'd4, 64'hB);
    #1;
    check_output("x4_coll_bypass", rdata(0), 64'hB);
    check_output("x4_coll_conflict_pre", {63'h0, bus.wr_conflict}, 64'h0);
    tick();
    idle();
    #1;
    check_output("x4_coll_stored", rdata(1), 64'hB);
    check_output("x4_coll_conflict", {63'h0, bus.wr_conflict}, 64'h1);
    tick();
    check_output("x4_coll_conflict_after", {63'h0, bus.wr_conflict}, 64'h0);

    // Two writes to x0, and two writes to distinct registers, are not collisions
    set_write(0, 5'd0, 64'h1);
    set_write(1, 5'd0, 64'h2);
    tick();
    idle();
    #1;
    check_output("x0_no_conflict", {63'h0, bus.wr_conflict}, 64'h0);
    set_write(0, 5'd10, 64'h10);
    set_write(1, 5'd11, 64'h11);
    tick();
    idle();
    set_read(0, 5'd10);
    set_read(1, 5'd11);
    #1;
    check_output("distinct_no_conflict", {63'h0, bus.wr_conflict}, 64'h0);
    check_output("distinct_x10", rdata(0), 64'h10);
    check_output("distinct_x11", rdata(1), 64'h11);

    // Reset in mid-operation drops the concurrent write and clears busy
    set_write(0, 5'd2, 64'h77);
    alloc(5'd6);
    tick();
    idle();
    set_read(0, 5'd2);
    set_read(1, 5'd6);
    #1;
    check_output("x2_before_reset", rdata(0), 64'h77);
    check_output("x6_busy_before_reset", {63'h0, bus.rd_busy[1]}, 64'h1);
    reset = 1'b1;
    set_write(0, 5'd2, 64'h99);
    #1;
    check_output("reset_forced_rd0", rdata(0), 64'h0);
    check_output("reset_forced_busy", {62'h0, bus.rd_busy}, 64'h0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    check_output("x2_after_reset", rdata(0), 64'h0);
    check_output("x6_busy_after_reset", {63'h0, bus.rd_busy[1]}, 64'h0);
    set_read(1, 5'd3);
    #1;
    check_output("x3_after_reset", rdata(1), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
